// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-ported memory,
// returning one-cycle acks, held read data and pipeline stall requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                stall_if,
  output logic                stall_dm,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  // Widths follow the module parameters, so the transaction record lives here.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_txn_t;

  // Handshakes: requesters hold req high until their one-cycle ack (or a
  // fetch kill); the memory completes in any cycle where mem_req and
  // mem_ready are both high, and mem_* stay frozen until then.

  arb_state_t       state_q, state_d;
  mem_txn_t         txn_q, txn_d;
  logic             mem_req_q;
  logic             if_ack_q, dm_ack_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic             drop_q;
  logic [CNT_W-1:0] starve_q;

  logic if_elig, dm_elig, starved;
  logic grant_if, grant_dm, done_if, done_dm;

  // A requester still showing req during its own ack cycle is not re-granted.
  assign if_elig = if_req & ~if_ack_q & ~if_kill;
  assign dm_elig = dm_req & ~dm_ack_q;
  assign starved = (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    done_if  = 1'b0;
    done_dm  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_elig && (!dm_elig || starved)) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
          txn_d    = '{we: 1'b0, addr: if_addr, wdata: '0, be: '0};
        end else if (dm_elig) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
          txn_d    = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, be: dm_be};
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          done_if = 1'b1;
          state_d = IDLE;
        end
      end
      BUSY_DM: begin
        if (mem_ready) begin
          done_dm = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      txn_q      <= '0;
      mem_req_q  <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      if_ack_q <= done_if & ~drop_q & ~if_kill;
      dm_ack_q <= done_dm;
      if (grant_if || grant_dm) begin
        mem_req_q <= 1'b1;
      end else if (done_if || done_dm) begin
        mem_req_q <= 1'b0;
      end
      // A killed fetch still completes on the bus but leaves no trace upstream.
      if (done_if && !drop_q && !if_kill) begin
        if_rdata_q <= mem_rdata;
      end
      if (done_dm) begin
        dm_rdata_q <= mem_rdata;
      end
      if (done_if) begin
        drop_q <= 1'b0;
      end else if (state_q == BUSY_IF && if_kill) begin
        drop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!if_req || grant_if) begin
      starve_q <= '0;
    end else if (grant_dm && if_elig && !starved) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = txn_q.we;
  assign mem_addr  = txn_q.addr;
  assign mem_wdata = txn_q.wdata;
  assign mem_be    = txn_q.be;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_dm  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for contention, starvation, kill and reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall_if;
  logic        stall_dm;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks;
  int errors;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic        exp_we;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction: request, grant, waits, ack, release.
  task automatic run_vec(input vec_t v);
    int   cyc;
    logic got;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk("vec stall on request", v.is_dm ? stall_dm : stall_if, 1'b1);
    step();
    cyc = 1;
    chk("vec mem_req at grant", mem_req, 1'b1);
    chk("vec mem_we", mem_we, v.exp_we);
    chk("vec mem_addr", mem_addr, v.addr);
    if (v.is_dm) begin
      chk("vec mem_wdata", mem_wdata, v.wdata);
      chk("vec mem_be", mem_be, v.be);
    end
    got = 1'b0;
    while (!got && cyc < 40) begin
      chk("vec mem_addr stable", mem_addr, v.addr);
      mem_ready = ((cyc - 1) == v.waits);
      mem_rdata = v.rdata;
      step();
      cyc++;
      got = v.is_dm ? dm_ack : if_ack;
    end
    mem_ready = 1'b0;
    chk("vec ack seen", got, 1'b1);
    chk("vec latency", cyc, v.exp_lat);
    chk("vec other ack quiet", v.is_dm ? if_ack : dm_ack, 1'b0);
    chk("vec mem_req released", mem_req, 1'b0);
    chk("vec stall in ack cycle", v.is_dm ? stall_dm : stall_if, 1'b0);
    if (!v.we) chk("vec rdata", v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
    if (v.is_dm) dm_req = 1'b0; else if_req = 1'b0;
    step();
    chk("vec ack one cycle", v.is_dm ? dm_ack : if_ack, 1'b0);
    if (!v.we) chk("vec rdata held", v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_t post;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    //            dm  we   addr       wdata         be       w  rdata         ewe  lat exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,         4'h0,    0, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h204, 32'h0,         4'hF,    1, 32'h0BADF00D, 1'b0, 3, 32'h0BADF00D};
    vecs[2] = '{1'b1, 1'b1, 32'h208, 32'hA5A55A5A,  4'b0011, 0, 32'h0,        1'b1, 2, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h104, 32'h0,         4'h0,    5, 32'h12345678, 1'b0, 7, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'h20C, 32'h0,         4'b1100, 2, 32'hCAFEBABE, 1'b0, 4, 32'hCAFEBABE};

    step();
    step();
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset if_ack", if_ack, 1'b0);
    chk("reset dm_ack", dm_ack, 1'b0);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset dm_rdata", dm_rdata, 32'h0);
    chk("reset stall_if", stall_if, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Simultaneous requests: the store goes first, then the fetch.
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h11223344; dm_be = 4'hF;
    #1;
    chk("both stall_if", stall_if, 1'b1);
    chk("both stall_dm", stall_dm, 1'b1);
    step();
    for (int w = 0; w < 4; w++) begin
      chk("both dm mem_req", mem_req, 1'b1);
      chk("both dm mem_we", mem_we, 1'b1);
      chk("both dm mem_addr", mem_addr, 32'h200);
      chk("both dm mem_wdata", mem_wdata, 32'h11223344);
      mem_ready = (w == 3);
      step();
    end
    mem_ready = 1'b0;
    chk("both dm_ack", dm_ack, 1'b1);
    chk("both if_ack waiting", if_ack, 1'b0);
    chk("both mem_req idle gap", mem_req, 1'b0);
    dm_req = 1'b0;
    step();
    chk("both dm_ack one cycle", dm_ack, 1'b0);
    chk("both if grant addr", mem_addr, 32'h400);
    chk("both if grant we", mem_we, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h44440000;
    step();
    mem_ready = 1'b0;
    chk("both if_ack", if_ack, 1'b1);
    chk("both if_rdata", if_rdata, 32'h44440000);
    if_req = 1'b0;
    step();
    chk("both if_ack one cycle", if_ack, 1'b0);

    // Starvation: kill pulses in each dm ack cycle keep the fetch from
    // taking that slot, so data wins four times before the fetch is forced.
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; dm_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("starve dm grant addr", mem_addr, 32'h600 + 32'(4 * k));
      mem_ready = 1'b1; mem_rdata = 32'h66000000 + 32'(k);
      step();
      mem_ready = 1'b0;
      chk("starve dm_ack", dm_ack, 1'b1);
      chk("starve dm_rdata", dm_rdata, 32'h66000000 + 32'(k));
      if_kill = 1'b1; dm_addr = 32'h600 + 32'(4 * (k + 1));
      step();
      if_kill = 1'b0;
      chk("starve no grant in kill slot", mem_req, 1'b0);
    end
    step();
    chk("starve forced if mem_req", mem_req, 1'b1);
    chk("starve forced if addr", mem_addr, 32'h500);
    chk("starve stall_dm waiting", stall_dm, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'h55550001;
    step();
    mem_ready = 1'b0;
    chk("starve if_ack", if_ack, 1'b1);
    chk("starve if_rdata", if_rdata, 32'h55550001);
    if_addr = 32'h504; dm_req = 1'b0;
    step();
    chk("starve no grant in ack cycle", mem_req, 1'b0);
    dm_req = 1'b1; dm_addr = 32'h680;
    step();
    chk("starve counter cleared dm wins", mem_addr, 32'h680);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("starve dm_ack after clear", dm_ack, 1'b1);
    dm_req = 1'b0;
    step();
    chk("starve next fetch addr", mem_addr, 32'h504);
    mem_ready = 1'b1; mem_rdata = 32'h55550002;
    step();
    mem_ready = 1'b0;
    chk("starve next if_ack", if_ack, 1'b1);
    if_req = 1'b0;
    step();

    // Kill during a fetch with two wait states.
    if_req = 1'b1; if_addr = 32'h700;
    step();
    chk("kill busy mem_req", mem_req, 1'b1);
    if_kill = 1'b1;
    step();
    if_kill = 1'b0; if_req = 1'b0;
    chk("kill not aborted", mem_req, 1'b1);
    chk("kill addr held", mem_addr, 32'h700);
    step();
    mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_ready = 1'b0;
    chk("kill no if_ack", if_ack, 1'b0);
    chk("kill if_rdata kept", if_rdata, 32'h55550002);
    chk("kill mem_req done", mem_req, 1'b0);
    if_req = 1'b1; if_addr = 32'h300;
    step();
    chk("kill refetch addr", mem_addr, 32'h300);
    mem_ready = 1'b1; mem_rdata = 32'h30003000;
    step();
    mem_ready = 1'b0;
    chk("kill refetch if_ack", if_ack, 1'b1);
    chk("kill refetch if_rdata", if_rdata, 32'h30003000);
    if_req = 1'b0;
    step();

    // Kill in the same cycle the memory completes.
    if_req = 1'b1; if_addr = 32'h800;
    step();
    mem_ready = 1'b1; if_kill = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ready = 1'b0; if_kill = 1'b0;
    chk("kill-ready no if_ack", if_ack, 1'b0);
    chk("kill-ready if_rdata kept", if_rdata, 32'h30003000);
    if_addr = 32'h804;
    step();
    chk("kill-ready refetch addr", mem_addr, 32'h804);
    mem_ready = 1'b1; mem_rdata = 32'h80408040;
    step();
    mem_ready = 1'b0;
    chk("kill-ready drop cleared ack", if_ack, 1'b1);
    chk("kill-ready refetch rdata", if_rdata, 32'h80408040);
    if_req = 1'b0;
    step();

    // Reset in the middle of a data access.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h900; dm_wdata = 32'h99; dm_be = 4'hF;
    step();
    chk("rst busy mem_req", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async mem_req", mem_req, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_be", mem_be, 4'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    chk("rst dm_ack", dm_ack, 1'b0);
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    post = '{1'b1, 1'b0, 32'hA00, 32'h0, 4'hF, 0, 32'h0A0A0A0A, 1'b0, 2, 32'h0A0A0A0A};
    run_vec(post);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
